// File: rtl/fault_led_ctrl_pkg.sv
// Shared state encoding and default parameters for the fault-indicator LED controller.
package fault_led_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HOLD   = 2'd2,
    ST_MEMORY = 2'd3
  } ch_state_t;

  localparam int DEF_N_CH        = 6;
  localparam int DEF_STRETCH_CYC = 1024;
  localparam int DEF_CNT_W       = 10;
  localparam int DEF_BLINK_DIV   = 4096;
  localparam logic [DEF_N_CH-1:0] DEF_LATCH_MASK = 6'b111111;

endpackage

// File: rtl/led_channel_fsm.sv
// One fault channel: input synchroniser, pulse-stretch FSM with optional fault memory,
// and the registered LED / memory flags.
module led_channel_fsm
  import fault_led_ctrl_pkg::*;
#(
  parameter int STRETCH_CYC = DEF_STRETCH_CYC,
  parameter int CNT_W       = DEF_CNT_W,
  parameter bit LATCH       = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic fault,
  input  logic clr,
  input  logic lamp_test,
  input  logic blink_phase,
  output logic led,
  output logic mem,
  output logic busy_nxt
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STRETCH_CYC - 1);

  logic            sync_r;
  logic            fs_r;
  ch_state_t       state_r;
  ch_state_t       state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic            led_r;
  logic            led_s;
  logic            mem_r;
  logic            busy_s;

  // Two-flop synchroniser for the asynchronous fault flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= 1'b0;
      fs_r   <= 1'b0;
    end else begin
      sync_r <= fault;
      fs_r   <= sync_r;
    end
  end

  // Next-state and stretch-count logic; a present fault always wins over clear.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (fs_r) state_s = ST_ACTIVE;
        else      state_s = ST_IDLE;
      end
      ST_ACTIVE: begin
        if (!fs_r) begin
          state_s = ST_HOLD;
          cnt_s   = CNT_LOAD;
        end else begin
          state_s = ST_ACTIVE;
        end
      end
      ST_HOLD: begin
        if (fs_r)                  state_s = ST_ACTIVE;
        else if (cnt_r == '0)      state_s = LATCH ? ST_MEMORY : ST_IDLE;
        else                       cnt_s   = cnt_r - CNT_W'(1);
      end
      ST_MEMORY: begin
        if (fs_r)      state_s = ST_ACTIVE;
        else if (clr)  state_s = ST_IDLE;
        else           state_s = ST_MEMORY;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Output decode from the next state so LED and flags change with the state itself.
  always_comb begin
    busy_s = (state_s == ST_ACTIVE) || (state_s == ST_HOLD);
    if (lamp_test) begin
      led_s = 1'b1;
    end else begin
      case (state_s)
        ST_ACTIVE: led_s = 1'b1;
        ST_HOLD:   led_s = 1'b1;
        ST_MEMORY: led_s = blink_phase;
        ST_IDLE:   led_s = 1'b0;
        default:   led_s = 1'b0;
      endcase
    end
  end

  // Channel state, stretch counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      led_r   <= 1'b0;
      mem_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      led_r   <= led_s;
      mem_r   <= (state_s == ST_MEMORY);
    end
  end

  assign led      = led_r;
  assign mem      = mem_r;
  assign busy_nxt = busy_s;

endmodule

// File: rtl/fault_led_ctrl.sv
// Fault-indicator LED controller: shared blink prescaler, one FSM per channel,
// and the registered any-fault summary.
module fault_led_ctrl
  import fault_led_ctrl_pkg::*;
#(
  parameter int              N_CH        = DEF_N_CH,
  parameter int              STRETCH_CYC = DEF_STRETCH_CYC,
  parameter int              CNT_W       = DEF_CNT_W,
  parameter int              BLINK_DIV   = DEF_BLINK_DIV,
  parameter logic [N_CH-1:0] LATCH_MASK  = DEF_LATCH_MASK
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] fault_i,
  input  logic            clr_i,
  input  logic            lamp_test_i,
  output logic [N_CH-1:0] led_o,
  output logic            any_fault_o,
  output logic [N_CH-1:0] mem_o
);

  localparam int PW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(BLINK_DIV - 1);

  logic [PW-1:0]   presc_r;
  logic            phase_r;
  logic [N_CH-1:0] busy_s;
  logic            any_fault_r;

  // Free-running blink prescaler; only reset clears it so all channels stay in phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_r <= '0;
      phase_r <= 1'b0;
    end else if (presc_r == PRESC_MAX) begin
      presc_r <= '0;
      phase_r <= ~phase_r;
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    led_channel_fsm #(
      .STRETCH_CYC (STRETCH_CYC),
      .CNT_W       (CNT_W),
      .LATCH       (LATCH_MASK[g])
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .fault       (fault_i[g]),
      .clr         (clr_i),
      .lamp_test   (lamp_test_i),
      .blink_phase (phase_r),
      .led         (led_o[g]),
      .mem         (mem_o[g]),
      .busy_nxt    (busy_s[g])
    );
  end

  // Summary flag registered from the channels' next states to align with led_o.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) any_fault_r <= 1'b0;
    else     any_fault_r <= |busy_s;
  end

  assign any_fault_o = any_fault_r;

endmodule
